// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt round scheduler: one-hot state
// encoding, statemt port-owner codes and the default round count.
package aes_dec_pkg;

    localparam int NR_DEFAULT = 10;

    // One-hot so every output decode is a single flop bit.
    typedef enum logic [7:0] {
        S_IDLE     = 8'b0000_0001,
        S_ARK_GO   = 8'b0000_0010,
        S_ARK_WAIT = 8'b0000_0100,
        S_ISB_GO   = 8'b0000_1000,
        S_ISB_WAIT = 8'b0001_0000,
        S_IMC_GO   = 8'b0010_0000,
        S_IMC_WAIT = 8'b0100_0000,
        S_DONE     = 8'b1000_0000
    } state_e;

    localparam logic [1:0] PSEL_NONE = 2'd0;
    localparam logic [1:0] PSEL_ARK  = 2'd1;
    localparam logic [1:0] PSEL_ISB  = 2'd2;
    localparam logic [1:0] PSEL_IMC  = 2'd3;

endpackage

// File: rtl/aes_dec_round_sched.sv
// Round scheduler for the AES decrypt core. Walks AddRoundKey,
// InvShiftRow+InvByteSub and InvMixColumn through their start/done
// handshakes, drives the AddRoundKey round index and picks the owner of
// the shared statemt ports. All outputs except ap_idle decode registers.
module aes_dec_round_sched
    import aes_dec_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic       ap_start,
    output logic       ap_done,
    output logic       ap_idle,
    output logic       ap_ready,
    output logic       ark_start,
    input  logic       ark_done,
    output logic [4:0] ark_n,
    output logic       isb_start,
    input  logic       isb_done,
    output logic       imc_start,
    input  logic       imc_done,
    output logic [1:0] port_sel,
    output logic [3:0] round
);

    localparam logic [3:0] NR_Q = 4'(NR);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;

    // Next-state and round counter update. A done input is only looked at
    // in its own WAIT state, since idle sub-blocks hold ap_done high.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    round_d = NR_Q;
                    state_d = S_ARK_GO;
                end
            end
            S_ARK_GO:   state_d = S_ARK_WAIT;
            S_ARK_WAIT: begin
                if (ark_done) begin
                    if (round_q == 4'd0) begin
                        state_d = S_DONE;
                    end else if (round_q == NR_Q) begin
                        round_d = NR_Q - 4'd1;
                        state_d = S_ISB_GO;
                    end else begin
                        state_d = S_IMC_GO;
                    end
                end
            end
            S_ISB_GO:   state_d = S_ISB_WAIT;
            S_ISB_WAIT: if (isb_done) state_d = S_ARK_GO;
            S_IMC_GO:   state_d = S_IMC_WAIT;
            S_IMC_WAIT: begin
                if (imc_done) begin
                    // Guard keeps the 4-bit counter from ever wrapping.
                    if (round_q != 4'd0) round_d = round_q - 4'd1;
                    state_d = S_ISB_GO;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State and round registers with asynchronous reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Port owner follows the active stage from GO through done acceptance.
    always_comb begin
        port_sel = PSEL_NONE;
        case (state_q)
            S_ARK_GO, S_ARK_WAIT: port_sel = PSEL_ARK;
            S_ISB_GO, S_ISB_WAIT: port_sel = PSEL_ISB;
            S_IMC_GO, S_IMC_WAIT: port_sel = PSEL_IMC;
            default:              port_sel = PSEL_NONE;
        endcase
    end

    assign ark_start = (state_q == S_ARK_GO);
    assign isb_start = (state_q == S_ISB_GO);
    assign imc_start = (state_q == S_IMC_GO);
    assign ap_done   = (state_q == S_DONE);
    assign ap_ready  = ap_done;
    assign ap_idle   = (state_q == S_IDLE) && !ap_start;
    assign ark_n     = {1'b0, round_q};
    assign round     = round_q;

endmodule
